// File: rtl/rectangle_sbox_layer_seq_if.sv
// Handshake and data bundle between the RECTANGLE S-layer sequencer, the
// round-state registers, the randomness source and the masked S-box datapath.
interface rectangle_sbox_layer_seq_if #(
  parameter int RND_W = 8
) ();
  logic             start;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [63:0]      in_c;
  logic             busy;
  logic             done;
  logic [63:0]      out_a;
  logic [63:0]      out_b;
  logic [63:0]      out_c;
  logic [RND_W-1:0] rnd_in;
  logic             rnd_vld;
  logic             rnd_rdy;
  logic             sb_vld;
  logic [3:0]       sb_x_a;
  logic [3:0]       sb_x_b;
  logic [3:0]       sb_x_c;
  logic [RND_W-1:0] sb_rnd;
  logic [3:0]       sb_y_a;
  logic [3:0]       sb_y_b;
  logic [3:0]       sb_y_c;

  // Environment side: round control, randomness source and S-box results.
  modport master (
    output start, in_a, in_b, in_c, rnd_in, rnd_vld, sb_y_a, sb_y_b, sb_y_c,
    input  busy, done, out_a, out_b, out_c, rnd_rdy, sb_vld,
           sb_x_a, sb_x_b, sb_x_c, sb_rnd
  );

  // Sequencer side.
  modport slave (
    input  start, in_a, in_b, in_c, rnd_in, rnd_vld, sb_y_a, sb_y_b, sb_y_c,
    output busy, done, out_a, out_b, out_c, rnd_rdy, sb_vld,
           sb_x_a, sb_x_b, sb_x_c, sb_rnd
  );
endinterface

// File: rtl/rectangle_sbox_layer_seq.sv
// Sequencer for the 3-share masked RECTANGLE S-layer. Holds the three state
// shares, issues the 16 columns one at a time to a fixed-latency masked S-box
// and writes each result column back in place.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; shares hold the last layer result
//   ST_ISSUE | issuing columns, one per cycle with valid randomness
//   ST_DRAIN | all columns issued, waiting for the remaining results
//   ST_FIN   | layer complete, done pulse
module rectangle_sbox_layer_seq #(
  parameter int LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  rectangle_sbox_layer_seq_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One retire-pipe entry is {valid, column index}.
  localparam int PW = 5;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [63:0]       r_a;
  logic [63:0]       r_b;
  logic [63:0]       r_c;
  logic [3:0]        r_issue_idx;
  logic [4:0]        r_retire_cnt;
  logic [PW*LAT-1:0] r_pipe;
  logic              w_load;
  logic              w_issue;
  logic              w_retire;
  logic [3:0]        w_ret_idx;
  logic [PW-1:0]     w_pipe_in;

  // Column j is {row3[j], row2[j], row1[j], row0[j]}; row r bit j is bit 16r+j.
  function automatic logic [3:0] get_col(input logic [63:0] s, input logic [3:0] j);
    return {s[{2'd3, j}], s[{2'd2, j}], s[{2'd1, j}], s[{2'd0, j}]};
  endfunction

  function automatic logic [63:0] put_col(input logic [63:0] s, input logic [3:0] j,
                                          input logic [3:0] y);
    logic [63:0] t;
    t              = s;
    t[{2'd0, j}]   = y[0];
    t[{2'd1, j}]   = y[1];
    t[{2'd2, j}]   = y[2];
    t[{2'd3, j}]   = y[3];
    return t;
  endfunction

  assign w_load    = (r_state == ST_IDLE) && io_bus.start;
  assign w_issue   = (r_state == ST_ISSUE) && io_bus.rnd_vld;
  assign w_pipe_in = {w_issue, r_issue_idx};
  assign w_retire  = r_pipe[PW*LAT-1];
  assign w_ret_idx = r_pipe[PW*LAT-2 -: 4];

  assign io_bus.busy    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign io_bus.done    = (r_state == ST_FIN);
  assign io_bus.rnd_rdy = (r_state == ST_ISSUE);
  assign io_bus.sb_vld  = w_issue;
  assign io_bus.sb_x_a  = get_col(r_a, r_issue_idx);
  assign io_bus.sb_x_b  = get_col(r_b, r_issue_idx);
  assign io_bus.sb_x_c  = get_col(r_c, r_issue_idx);
  assign io_bus.sb_rnd  = io_bus.rnd_in;
  assign io_bus.out_a   = r_a;
  assign io_bus.out_b   = r_b;
  assign io_bus.out_c   = r_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the layer ends on the edge that writes the 16th result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (io_bus.start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_issue && (r_issue_idx == 4'd15)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_retire && (r_retire_cnt == 5'd15)) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue index advances only on an actual issue; retire count tracks write-backs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_idx  <= 4'd0;
      r_retire_cnt <= 5'd0;
    end else if (w_load) begin
      r_issue_idx  <= 4'd0;
      r_retire_cnt <= 5'd0;
    end else begin
      if (w_issue)  r_issue_idx  <= r_issue_idx + 4'd1;
      if (w_retire) r_retire_cnt <= r_retire_cnt + 5'd1;
    end
  end

  // Retire pipe mirrors the datapath latency so the tail lines up with sb_y_*.
  generate
    if (LAT == 1) begin : g_pipe_1
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= w_pipe_in;
      end
    end else begin : g_pipe_n
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[PW*(LAT-1)-1:0], w_pipe_in};
      end
    end
  endgenerate

  // Share registers: load on accepted start, in-place column write-back per share.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= 64'd0;
      r_b <= 64'd0;
      r_c <= 64'd0;
    end else if (w_load) begin
      r_a <= io_bus.in_a;
      r_b <= io_bus.in_b;
      r_c <= io_bus.in_c;
    end else if (w_retire) begin
      r_a <= put_col(r_a, w_ret_idx, io_bus.sb_y_a);
      r_b <= put_col(r_b, w_ret_idx, io_bus.sb_y_b);
      r_c <= put_col(r_c, w_ret_idx, io_bus.sb_y_c);
    end
  end

endmodule

// File: tb/tb_rectangle_sbox_layer_seq.sv
// Bench for rectangle_sbox_layer_seq: three DUT lanes (LAT = 1, 2, 4) share the
// same stimulus; each lane has its own masked S-box model of matching latency.
module tb_rectangle_sbox_layer_seq;

  localparam int RND_W = 8;
  localparam int NL    = 3;
  localparam logic [3:0] SBOX [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                       4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

  typedef struct {
    string       tag;
    logic [63:0] u;         // unmasked input state
    logic [63:0] lowmask;   // bit n set: rnd_vld low in cycle n
    bit          spurious;  // pulse start in cycles 5 and 12
    logic [63:0] exp_layer; // expected unmasked result
    int          exp_late;  // expected done delay from low rnd_vld cycles
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [63:0]       in_a, in_b, in_c;
  logic [RND_W-1:0]  rnd_in;
  logic              rnd_vld;

  logic              busy_l [NL];
  logic              done_l [NL];
  logic              rdy_l  [NL];
  logic              sbv_l  [NL];
  logic [63:0]       oa_l   [NL];
  logic [63:0]       ob_l   [NL];
  logic [63:0]       oc_l   [NL];
  logic [3:0]        sxa_l  [NL];
  logic [3:0]        sxb_l  [NL];
  logic [3:0]        sxc_l  [NL];
  logic [RND_W-1:0]  srnd_l [NL];
  int                vcnt_l [NL];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    rectangle_sbox_layer_seq_if #(.RND_W(RND_W)) u_if ();
    logic [12*L-1:0] r_sb_pipe = '0;
    logic [3:0]      w_x, w_ya, w_yb;
    int              r_vcnt = 0;

    assign u_if.start   = start;
    assign u_if.in_a    = in_a;
    assign u_if.in_b    = in_b;
    assign u_if.in_c    = in_c;
    assign u_if.rnd_in  = rnd_in;
    assign u_if.rnd_vld = rnd_vld;

    // Masked S-box model: shares a,b come from randomness, c completes S(x).
    assign w_x  = u_if.sb_x_a ^ u_if.sb_x_b ^ u_if.sb_x_c;
    assign w_ya = u_if.sb_rnd[3:0];
    assign w_yb = u_if.sb_rnd[7:4];
    always @(posedge clk) begin
      r_sb_pipe        <= r_sb_pipe << 12;
      r_sb_pipe[11:0]  <= {w_ya, w_yb, SBOX[w_x] ^ w_ya ^ w_yb};
      if (u_if.sb_vld) r_vcnt <= r_vcnt + 1;
    end
    assign u_if.sb_y_a = r_sb_pipe[12*L-1 -: 4];
    assign u_if.sb_y_b = r_sb_pipe[12*L-5 -: 4];
    assign u_if.sb_y_c = r_sb_pipe[12*L-9 -: 4];

    rectangle_sbox_layer_seq #(.LAT(L)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_if)
    );

    assign busy_l[k] = u_if.busy;
    assign done_l[k] = u_if.done;
    assign rdy_l[k]  = u_if.rnd_rdy;
    assign sbv_l[k]  = u_if.sb_vld;
    assign oa_l[k]   = u_if.out_a;
    assign ob_l[k]   = u_if.out_b;
    assign oc_l[k]   = u_if.out_c;
    assign sxa_l[k]  = u_if.sb_x_a;
    assign sxb_l[k]  = u_if.sb_x_b;
    assign sxc_l[k]  = u_if.sb_x_c;
    assign srnd_l[k] = u_if.sb_rnd;
    assign vcnt_l[k] = r_vcnt;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [3:0] col_of(input logic [63:0] v, input int j);
    logic [5:0] j6;
    j6 = 6'(j);
    return {v[j6 + 6'd48], v[j6 + 6'd32], v[j6 + 6'd16], v[j6]};
  endfunction

  function automatic logic [63:0] put_col(input logic [63:0] v, input int j, input logic [3:0] y);
    logic [5:0]  j6;
    logic [63:0] t;
    j6 = 6'(j);
    t = v;
    t[j6]          = y[0];
    t[j6 + 6'd16]  = y[1];
    t[j6 + 6'd32]  = y[2];
    t[j6 + 6'd48]  = y[3];
    return t;
  endfunction

  // Reference RECTANGLE substitution layer on an unmasked state.
  function automatic logic [63:0] ref_slayer(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r = put_col(r, j, SBOX[col_of(v, j)]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_layer(input string tag, input logic [63:0] u, input logic [63:0] lowmask,
                           input bit spurious, input logic [63:0] exp_layer, input int exp_late);
    logic [63:0] a, b, c, ea, eb, ec;
    logic [7:0]  rc [16];
    int          issued, nlow, late;
    int          done_at [NL];
    int          done_n  [NL];
    int          v0      [NL];
    bit          v, exp_busy;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = u ^ a ^ b;
    ea = '0; eb = '0; ec = '0;
    issued = 0;
    nlow   = 0;
    for (int k = 0; k < NL; k++) begin
      v0[k] = vcnt_l[k];
      done_at[k] = -1;
      done_n[k]  = 0;
    end
    start   = 1'b1;
    in_a    = a;
    in_b    = b;
    in_c    = c;
    rnd_vld = 1'($urandom);
    rnd_in  = 8'($urandom);
    for (int n = 1; n < 60; n++) begin
      @(negedge clk);
      late = (exp_late < 0) ? nlow : exp_late;
      for (int k = 0; k < NL; k++) begin
        exp_busy = (issued < 16) || (n < 17 + lat_of(k) + late);
        chk($sformatf("%s_rnd_rdy_l%0d_c%0d", tag, k, n), 64'(rdy_l[k]), 64'(issued < 16));
        chk($sformatf("%s_busy_l%0d_c%0d", tag, k, n), 64'(busy_l[k]), 64'(exp_busy));
        if (done_l[k] === 1'b1) begin
          done_n[k]++;
          if (done_at[k] < 0) begin
            done_at[k] = n;
            chk($sformatf("%s_share_a_l%0d", tag, k), oa_l[k], ea);
            chk($sformatf("%s_share_b_l%0d", tag, k), ob_l[k], eb);
            chk($sformatf("%s_share_c_l%0d", tag, k), oc_l[k], ec);
            chk($sformatf("%s_unmasked_l%0d", tag, k), oa_l[k] ^ ob_l[k] ^ oc_l[k], exp_layer);
          end
        end
      end
      start  = spurious && (n == 5 || n == 12);
      in_a   = {$urandom, $urandom};
      in_b   = {$urandom, $urandom};
      in_c   = {$urandom, $urandom};
      rnd_in = 8'($urandom);
      if (issued < 16) begin
        v = !lowmask[6'(n)];
        rnd_vld = v;
        if (v) begin
          rc[issued] = rnd_in;
          issued++;
          if (issued == 16) begin
            for (int j = 0; j < 16; j++) begin
              ea = put_col(ea, j, rc[j][3:0]);
              eb = put_col(eb, j, rc[j][7:4]);
              ec = put_col(ec, j, SBOX[col_of(u, j)] ^ rc[j][3:0] ^ rc[j][7:4]);
            end
          end
        end else begin
          nlow++;
        end
      end else begin
        rnd_vld = 1'($urandom);
      end
    end
    late = (exp_late < 0) ? nlow : exp_late;
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("%s_done_cycle_l%0d", tag, k), 64'(done_at[k]), 64'(17 + lat_of(k) + late));
      chk($sformatf("%s_done_count_l%0d", tag, k), 64'(done_n[k]), 64'd1);
      chk($sformatf("%s_sb_vld_pulses_l%0d", tag, k), 64'(vcnt_l[k] - v0[k]), 64'd16);
      chk($sformatf("%s_hold_l%0d", tag, k), oa_l[k] ^ ob_l[k] ^ oc_l[k], exp_layer);
    end
  endtask

  // Reset asserted in cycle 8 of a run: nothing from the aborted layer may surface.
  task automatic run_abort();
    int done_n, stale;
    done_n = 0;
    stale  = 0;
    start   = 1'b1;
    in_a    = {$urandom, $urandom};
    in_b    = {$urandom, $urandom};
    in_c    = {$urandom, $urandom};
    rnd_vld = 1'b1;
    rnd_in  = 8'($urandom);
    for (int n = 1; n < 36; n++) begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (done_l[k] === 1'b1) done_n++;
        if (n >= 9 && (oa_l[k] !== 64'd0 || ob_l[k] !== 64'd0 || oc_l[k] !== 64'd0)) stale++;
        if (n == 9) begin
          chk($sformatf("abort_busy_l%0d", k), 64'(busy_l[k]), 64'd0);
          chk($sformatf("abort_rnd_rdy_l%0d", k), 64'(rdy_l[k]), 64'd0);
          chk($sformatf("abort_out_a_l%0d", k), oa_l[k], 64'd0);
        end
      end
      start   = 1'b0;
      rst     = (n == 8);
      rnd_vld = (n < 8) ? 1'b1 : 1'($urandom);
      rnd_in  = 8'($urandom);
    end
    chk("abort_done_pulses", 64'(done_n), 64'd0);
    chk("abort_stale_writes", 64'(stale), 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"zero",  64'h0,                  64'h0,                     1'b0, 64'h0000_FFFF_FFFF_0000, 0};
    vecs[1] = '{"ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'h80,                   1'b0, 64'h0000_0000_FFFF_0000, 1};
    vecs[2] = '{"row0",  64'h0000_0000_0000_FFFF, 64'h0,                    1'b1, 64'h0000_FFFF_0000_FFFF, 0};
    vecs[3] = '{"row2",  64'h0000_FFFF_0000_0000, 64'h6,                    1'b0, 64'h0000_0000_0000_FFFF, 2};
    vecs[4] = '{"ref",   64'h0123_4567_89AB_CDEF, 64'h418,                  1'b0, 64'h0,                   3};
    vecs[5] = '{"spur",  64'h0123_4567_89AB_CDEF, 64'h0,                    1'b1, 64'h0,                   0};
    vecs[4].exp_layer = ref_slayer(vecs[4].u);
    vecs[5].exp_layer = ref_slayer(vecs[5].u);

    // Reset with inputs toggling and start held high.
    rst     = 1'b1;
    start   = 1'b1;
    rnd_vld = 1'b1;
    rnd_in  = 8'($urandom);
    in_a    = {$urandom, $urandom};
    in_b    = {$urandom, $urandom};
    in_c    = {$urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        chk($sformatf("rst_busy_l%0d_c%0d", k, c), 64'(busy_l[k]), 64'd0);
        chk($sformatf("rst_done_l%0d_c%0d", k, c), 64'(done_l[k]), 64'd0);
        chk($sformatf("rst_rnd_rdy_l%0d_c%0d", k, c), 64'(rdy_l[k]), 64'd0);
        chk($sformatf("rst_sb_vld_l%0d_c%0d", k, c), 64'(sbv_l[k]), 64'd0);
        chk($sformatf("rst_out_l%0d_c%0d", k, c), oa_l[k] | ob_l[k] | oc_l[k], 64'd0);
        chk($sformatf("rst_sb_x_l%0d_c%0d", k, c), 64'({sxa_l[k], sxb_l[k], sxc_l[k]}), 64'd0);
        chk($sformatf("rst_sb_rnd_l%0d_c%0d", k, c), 64'(srnd_l[k]), 64'(rnd_in));
      end
      rnd_in  = 8'($urandom);
      rnd_vld = 1'($urandom);
      in_a    = {$urandom, $urandom};
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("rst_start_ignored_l%0d", k), 64'(busy_l[k]), 64'd0);
      chk($sformatf("rst_no_load_l%0d", k), oa_l[k] | ob_l[k] | oc_l[k], 64'd0);
    end

    for (int i = 0; i < 6; i++)
      run_layer(vecs[i].tag, vecs[i].u, vecs[i].lowmask, vecs[i].spurious,
                vecs[i].exp_layer, vecs[i].exp_late);

    run_abort();
    begin
      logic [63:0] u;
      u = {$urandom, $urandom};
      run_layer("post_rst", u, 64'h0, 1'b0, ref_slayer(u), 0);
    end

    for (int i = 0; i < 3; i++) begin
      logic [63:0] u, m;
      u = {$urandom, $urandom};
      m = 64'({$urandom} & {$urandom} & 32'h001F_FFFE);
      run_layer($sformatf("rand%0d", i), u, m, 1'b0, ref_slayer(u), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rectangle_sbox_layer_seq.md
# rectangle_sbox_layer_seq

Sequencer for the 3-share, second-order masked RECTANGLE substitution layer. It holds the three 64-bit state shares and serialises the 16 four-bit columns through one shared, fixed-latency masked S-box datapath built from the component-function share modules. It writes each result column back in place and raises `done` when the whole layer has been substituted. It sits between the round-state registers and the masked S-box instance, and it gates each column issue on availability of fresh randomness.

## Interface
- `LAT`, 2: pipeline latency of the masked S-box datapath in cycles. Must be ≥1.
- `RND_W`, 8: fresh-randomness bits consumed per column issue.
- `clk` in 1: single clock; all flops sample on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load shares and begin a layer. Sampled only in IDLE.
- `in_a`, `in_b`, `in_c` in 64 each: input state shares. Row r, bit j is bit 16r+j.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: single-cycle pulse when the layer is complete.
- `out_a`, `out_b`, `out_c` out 64 each: state share registers.
- `rnd_in` in RND_W: fresh randomness.
- `rnd_vld` in 1: `rnd_in` is valid.
- `rnd_rdy` out 1: the sequencer can consume randomness this cycle.
- `sb_vld` out 1: a column issue to the S-box datapath.
- `sb_x_a`, `sb_x_b`, `sb_x_c` out 4 each: column shares.
- `sb_rnd` out RND_W: randomness forwarded to the datapath.
- `sb_y_a`, `sb_y_b`, `sb_y_c` in 4 each: result shares, valid exactly LAT cycles after the matching `sb_vld`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE to ISSUE on `start`. The same edge loads `in_*` into the share registers and clears both counters.
  - ISSUE to DRAIN on the edge that issues column 15.
  - DRAIN to FIN on the edge that captures the 16th result.
  - FIN to IDLE unconditionally.
- Column j of a share is `{row3[j], row2[j], row1[j], row0[j]}` = bits {48+j, 32+j, 16+j, j}. Bit 0 is the LSB of the nibble.
- Issue path:
  - `rnd_rdy` = (state == ISSUE).
  - `sb_vld` = `rnd_rdy` & `rnd_vld`.
  - `sb_x_*` is combinational from the share registers at the 4-bit issue index.
  - `sb_rnd` = `rnd_in`.
  - The issue index increments only on `sb_vld`.
- Retire path: a LAT-deep shift register of {valid, 4-bit index}. The datapath cannot stall, so retirement follows issue by exactly LAT cycles with no backpressure. When the tail entry is valid, `sb_y_*` is written to that column of `out_*`. A 5-bit retire counter counts writes.
- No hazard: each column is read once before its own write-back. Other columns are unaffected.
- Per-column share mapping is preserved: `sb_y_a` goes to `out_a`, and so on. Shares are never XORed together inside this block.
- `start` in any state other than IDLE is ignored.
- `rnd_vld` outside ISSUE is ignored. No randomness is consumed.
- Reset at any time, including mid-layer:
  - FSM returns to IDLE; counters and the valid pipe are cleared.
  - `out_*` go to 0.
  - Results still in flight are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `rnd_rdy`=0, `sb_vld`=0, `out_*`=0. `sb_x_*` reads column 0 of the zeroed registers, so it is 0. `sb_rnd` follows `rnd_in`.
- With `start` accepted at edge 0 and `rnd_vld` held high:
  - column j is issued in cycle 1+j;
  - it is captured at the end of cycle 1+j+LAT;
  - `done` is high in cycle 17+LAT.
- Each low-`rnd_vld` cycle during ISSUE delays every later event by one cycle.
- `busy` drops in the same cycle that `done` is high. `out_*` hold the substituted state from that cycle until the next accepted `start` or `rst`.
- Back-to-back layers are allowed: `start` asserted in the cycle after `done` is accepted.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs toggling. All outputs must hold the reset values above, and `start` must be ignored while `rst`=1.
- All-zero shares, LAT=2, `rnd_vld`=1, bench S-box model: `done` in cycle 19. XOR of the output shares must equal 64'h0000_FFFF_FFFF_0000, since S(0)=6. Exactly 16 `sb_vld` pulses.
- Random shares whose unmasked value is 64'h0123_4567_89AB_CDEF:
  - output unmasked value must equal the reference RECTANGLE S-layer;
  - `rnd_vld` low on issue cycles 3, 4 and 10 makes `done` arrive 3 cycles late (cycle 22);
  - `rnd_rdy` must be high throughout ISSUE.
- `start` pulsed in cycles 5 and 12 of a run: it must be ignored, with no reload and no change to `out_*` or to `done` timing.
- `rst` asserted in cycle 8 of a run, then a fresh `start`: no `done` from the aborted run, no stale write-back, and the second run is correct and completes in 17+LAT cycles.
- LAT=1 and LAT=4 builds with the same stimulus: `done` in cycles 18 and 21, with identical final shares given identical S-box model outputs.
